// File: rtl/rca_grid_lsq.sv
// Grid-row load/store queue: in-order FIFO of row requests issued one at a time to a word-wide memory port.
// Optional RCA_LSQ_MISALIGN_CHECK_EN: misaligned H/W accesses are retired locally instead of issued.
module rca_grid_lsq #(
  parameter int GRID_NUM_ROWS = 4,
  parameter int LSQ_DEPTH     = 8,
  parameter int XLEN          = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]  lsq_addr,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]  lsq_data,
  input  logic [GRID_NUM_ROWS-1:0][2:0]       lsq_fn3,
  input  logic [GRID_NUM_ROWS-1:0]            lsq_load,
  input  logic [GRID_NUM_ROWS-1:0]            lsq_store,
  input  logic [GRID_NUM_ROWS-1:0]            lsq_new_request,
  output logic                                lsq_fifo_full,
  output logic [XLEN-1:0]                     lsq_load_data,
  output logic [GRID_NUM_ROWS-1:0]            lsq_load_complete,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [XLEN-1:0]                     mem_addr,
  output logic [3:0]                          mem_be,
  output logic [XLEN-1:0]                     mem_wdata,
  input  logic                                mem_ack,
  input  logic                                mem_rvalid,
  input  logic [XLEN-1:0]                     mem_rdata
);

  localparam int RW = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int PW = $clog2(LSQ_DEPTH);
  localparam int CW = PW + 1;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [RW-1:0]   row;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LD} state_t;

  function automatic logic [3:0] lane_be(input logic [2:0] fn3, input logic [1:0] off);
    case (fn3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] fn3, input logic [XLEN-1:0] d);
    case (fn3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ld_extract(input logic [2:0] fn3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = raw[{off[1], 4'b0000} +: 16];
    case (fn3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return raw;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] fn3, input logic [1:0] off);
    return MIS_CHK && (((fn3[1:0] == 2'b01) && off[0]) || ((fn3[1:0] == 2'b10) && (off != 2'b00)));
  endfunction

  state_t                   state_q, state_d;
  entry_t                   fifo_q [LSQ_DEPTH];
  entry_t                   fifo_d [LSQ_DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
  logic [CW-1:0]            count_q, count_d, n_enq;
  logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]               mem_be_q, mem_be_d;
  logic [RW-1:0]            cur_row_q, cur_row_d;
  logic [2:0]               cur_fn3_q, cur_fn3_d;
  logic [1:0]               cur_off_q, cur_off_d;
  logic                     killed_q, killed_d;
  logic [XLEN-1:0]          load_data_q, load_data_d;
  logic [GRID_NUM_ROWS-1:0] load_complete_q, load_complete_d;
  logic                     pop, launch, kill_now;
  entry_t                   head, nxt, src, new_ent;

  assign lsq_fifo_full = (int'(count_q) + GRID_NUM_ROWS) > LSQ_DEPTH;
  assign head          = fifo_q[rd_ptr_q];
  assign nxt           = fifo_q[rd_ptr_q + PW'(1)];
  assign kill_now      = killed_q | flush;

  // Enqueue: accepted rows are packed into consecutive slots, lowest row first
  always_comb begin
    fifo_d  = fifo_q;
    wr_idx  = wr_ptr_q;
    n_enq   = '0;
    new_ent = '0;
    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      if (lsq_new_request[r] && !lsq_fifo_full && !flush) begin
        new_ent.row    = RW'(r);
        new_ent.addr   = lsq_addr[r];
        new_ent.data   = lsq_data[r];
        new_ent.fn3    = lsq_fn3[r];
        new_ent.load   = lsq_load[r] && !lsq_store[r];
        fifo_d[wr_idx] = new_ent;
        wr_idx         = wr_idx + PW'(1);
        n_enq          = n_enq + CW'(1);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;
    cur_row_d       = cur_row_q;
    cur_fn3_d       = cur_fn3_q;
    cur_off_d       = cur_off_q;
    killed_d        = killed_q;
    load_data_d     = load_data_q;
    load_complete_d = '0;
    pop             = 1'b0;
    launch          = 1'b0;
    src             = (state_q == ISSUE) ? nxt : head;

    case (state_q)
      IDLE: begin
        if (!flush && (count_q != '0)) begin
          if (misaligned(head.fn3, head.addr[1:0])) begin
            pop = 1'b1;
            if (head.load) begin
              load_complete_d[head.row] = 1'b1;
              load_data_d               = '0;
            end
          end else begin
            launch = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Request held stable until accepted, even across a flush
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          pop       = !kill_now;
          if (!mem_we_q) begin
            state_d = WAIT_LD;
          end else if (!kill_now && (count_q > CW'(1)) && !misaligned(nxt.fn3, nxt.addr[1:0])) begin
            launch = 1'b1;
          end
        end
      end
      WAIT_LD: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (!kill_now) begin
            load_data_d                = ld_extract(cur_fn3_q, cur_off_q, mem_rdata);
            load_complete_d[cur_row_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d     = ISSUE;
      mem_req_d   = 1'b1;
      mem_we_d    = !src.load;
      mem_addr_d  = {src.addr[XLEN-1:2], 2'b00};
      mem_be_d    = lane_be(src.fn3, src.addr[1:0]);
      mem_wdata_d = lane_wdata(src.fn3, src.data);
      cur_row_d   = src.row;
      cur_fn3_d   = src.fn3;
      cur_off_d   = src.addr[1:0];
    end
    if (!mem_req_d) begin
      mem_we_d = 1'b0;
      mem_be_d = '0;
    end

    if (state_d == IDLE || launch) begin
      killed_d = 1'b0;
    end else if (flush) begin
      killed_d = 1'b1;
    end
    if (flush) begin
      load_data_d = '0;
    end

    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_idx;
    count_d  = count_q + n_enq - CW'(pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= '0;
      killed_q        <= 1'b0;
      load_data_q     <= '0;
      load_complete_q <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      killed_q        <= killed_d;
      load_data_q     <= load_data_d;
      load_complete_q <= load_complete_d;
    end
    fifo_q      <= fifo_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    cur_row_q   <= cur_row_d;
    cur_fn3_q   <= cur_fn3_d;
    cur_off_q   <= cur_off_d;
  end

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_be            = mem_be_q;
  assign mem_wdata         = mem_wdata_q;
  assign lsq_load_data     = load_data_q;
  assign lsq_load_complete = load_complete_q;

endmodule

// File: tb/tb_rca_grid_lsq.sv
// Directed bench for rca_grid_lsq (4 rows, 8 entries); covers RCA_LSQ_MISALIGN_CHECK_EN either way.
module tb_rca_grid_lsq;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [3:0][31:0] addr_v, data_v;
  logic [3:0][2:0]  fn3_v;
  logic [3:0]       load_v, store_v, newreq_v;
  logic             fifo_full;
  logic [31:0]      load_data;
  logic [3:0]       load_complete;
  logic             mem_req, mem_we, mem_ack, mem_rvalid;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_be;
  int               n_cmp = 0;
  int               n_bad = 0;

  rca_grid_lsq #(.GRID_NUM_ROWS(4), .LSQ_DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_addr(addr_v), .lsq_data(data_v), .lsq_fn3(fn3_v),
    .lsq_load(load_v), .lsq_store(store_v), .lsq_new_request(newreq_v),
    .lsq_fifo_full(fifo_full), .lsq_load_data(load_data), .lsq_load_complete(load_complete),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int row, input bit is_load, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    newreq_v[row] = 1'b1;
    load_v[row]   = is_load;
    store_v[row]  = !is_load;
    fn3_v[row]    = f3;
    addr_v[row]   = a;
    data_v[row]   = d;
  endtask

  task automatic clear_req();
    newreq_v = '0;
    load_v   = '0;
    store_v  = '0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      tick();
    end
    check(tag, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic do_load(input string tag, input int row, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [31:0] raw, input logic [31:0] exp);
    set_req(row, 1'b1, f3, a, 32'd0);
    tick();
    clear_req();
    tick();
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    mem_ack = 1'b1;
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = raw;
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_data"}, load_data, exp);
    check({tag, "_cmpl"}, {28'd0, load_complete}, 32'd1 << row);
  endtask

  task automatic do_store(input string tag, input int row, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    set_req(row, 1'b0, f3, a, d);
    tick();
    clear_req();
    tick();
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    tick();
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    check({tag, "_wdata"}, mem_wdata, exp_wd);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    tick();
    check({tag, "_no_cmpl"}, {28'd0, load_complete}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    addr_v = '0; data_v = '0; fn3_v = '0;
    clear_req();
    tick();
    tick();
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_cmpl", {28'd0, load_complete}, 32'd0);
    check("rst_ldata", load_data, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b0;
    tick();

    // Row1 LW 0x100, rvalid two cycles after the ack
    set_req(1, 1'b1, 3'b010, 32'h100, 32'd0);
    tick();
    clear_req();
    tick();
    check("lw_req", {31'd0, mem_req}, 32'd1);
    check("lw_we", {31'd0, mem_we}, 32'd0);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_be", {28'd0, mem_be}, 32'hF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lw_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_no_early", {28'd0, load_complete}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    check("lw_data", load_data, 32'hDEADBEEF);
    check("lw_cmpl", {28'd0, load_complete}, 32'h2);
    tick();
    check("lw_cmpl_pulse", {28'd0, load_complete}, 32'h0);

    do_store("sb", 0, 3'b000, 32'h103, 32'h000000A5, 32'h100, 4'b1000, 32'hA5A5A5A5);
    do_store("sh", 2, 3'b001, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12341234);

    do_load("lb",  2, 3'b000, 32'h102, 32'h100, 32'h0080FF00, 32'hFFFFFF80);
    do_load("lbu", 2, 3'b100, 32'h102, 32'h100, 32'h0080FF00, 32'h00000080);
    do_load("lh",  3, 3'b001, 32'h100, 32'h100, 32'h0080FF00, 32'hFFFFFF00);
    do_load("lhu", 0, 3'b101, 32'h100, 32'h100, 32'h0080FF00, 32'h0000FF00);

    // All rows request every cycle with memory stalled: two full batches fit, later ones dropped
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) set_req(r, 1'b1, 3'b010, 32'h1000 * (c + 1) + 32'h10 * r, 32'd0);
      check($sformatf("full_c%0d", c), {31'd0, fifo_full}, (c >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    clear_req();
    for (int k = 0; k < 8; k++) begin
      wait_req($sformatf("drain_req%0d", k));
      check($sformatf("drain_addr%0d", k), mem_addr, 32'h1000 * (k / 4 + 1) + 32'h10 * (k % 4));
      mem_ack = 1'b1;
      tick();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA0000000 + k;
      tick();
      mem_rvalid = 1'b0;
      check($sformatf("drain_cmpl%0d", k), {28'd0, load_complete}, 32'd1 << (k % 4));
      check($sformatf("drain_data%0d", k), load_data, 32'hA0000000 + k);
    end
    tick();
    tick();
    check("drain_empty_req", {31'd0, mem_req}, 32'd0);
    check("drain_full", {31'd0, fifo_full}, 32'd0);

    // Flush while the request is still waiting for ack
    set_req(1, 1'b1, 3'b010, 32'h400, 32'd0);
    tick();
    clear_req();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fiss_req_held", {31'd0, mem_req}, 32'd1);
    check("fiss_addr_held", mem_addr, 32'h400);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("fiss_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    tick();
    mem_rvalid = 1'b0;
    check("fiss_no_cmpl", {28'd0, load_complete}, 32'd0);

    // Flush in WAIT_LD with three entries queued behind the load
    set_req(0, 1'b1, 3'b010, 32'h300, 32'd0);
    tick();
    clear_req();
    for (int r = 1; r < 4; r++) set_req(r, 1'b1, 3'b010, 32'h300 + 32'h10 * r, 32'd0);
    tick();
    clear_req();
    check("fwt_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    check("fwt_full", {31'd0, fifo_full}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    check("fwt_no_cmpl", {28'd0, load_complete}, 32'd0);
    check("fwt_ldata", load_data, 32'd0);
    tick();
    tick();
    check("fwt_empty_req", {31'd0, mem_req}, 32'd0);
    do_load("recov", 3, 3'b010, 32'h500, 32'h500, 32'h12345678, 32'h12345678);

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    // Misaligned LW retires locally with zero data
    set_req(2, 1'b1, 3'b010, 32'h102, 32'd0);
    tick();
    clear_req();
    tick();
    check("mis_no_req", {31'd0, mem_req}, 32'd0);
    check("mis_cmpl", {28'd0, load_complete}, 32'h4);
    check("mis_data", load_data, 32'd0);
    tick();
    check("mis_still_no_req", {31'd0, mem_req}, 32'd0);
`else
    do_load("mis_lw", 2, 3'b010, 32'h102, 32'h100, 32'hCAFEF00D, 32'hCAFEF00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
